// File: rtl/kf_frame_feeder.sv
// rtl/kf_frame_feeder.sv - sample FIFO with sign-magnitude conversion and frame launch/tracking for kf_top
module kf_frame_feeder #(
  parameter int W       = 24,
  parameter int NLOAD   = 6,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       in_ready,
  input  logic                       READY,
  output logic                       START,
  output logic [W-1:0]               DATA_IN,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       sat_flag,
  output logic [15:0]                frame_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = $clog2(NLOAD + 1);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [KW-1:0] k;
  logic [CW-1:0] cnt;
  logic          push, pop, launch;
  logic [W-1:0]  neg_data, conv_word;
  logic          conv_sat;

  assign in_ready   = (level < LW'(DEPTH));
  assign fifo_level = level;
  assign push       = in_valid && in_ready;
  assign launch     = (state == IDLE) && (level >= LW'(NLOAD)) && READY;
  assign pop        = launch || ((state == LOAD) && (k < KW'(NLOAD)));

  // Most-negative input has no positive counterpart; clamp to max magnitude.
  always_comb begin
    neg_data  = -in_data;
    conv_sat  = 1'b0;
    conv_word = {1'b0, in_data[W-2:0]};
    if (in_data[W-1]) begin
      if (in_data[W-2:0] == '0) begin
        conv_word = '1;
        conv_sat  = 1'b1;
      end else begin
        conv_word = {1'b1, neg_data[W-2:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= conv_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      k          <= '0;
      cnt        <= '0;
      START      <= 1'b0;
      DATA_IN    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      sat_flag   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      START      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (push && conv_sat) sat_flag <= 1'b1;

      case (state)
        IDLE: begin
          DATA_IN <= '0;
          if (launch) begin
            START   <= 1'b1;
            DATA_IN <= mem[rd_ptr];
            k       <= KW'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (k < KW'(NLOAD)) begin
            DATA_IN <= mem[rd_ptr];
            k       <= k + KW'(1);
          end else begin
            DATA_IN <= '0;
            cnt     <= '0;
            state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!READY) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (READY) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            state      <= IDLE;
          end else if (cnt == CW'(TIMEOUT)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
